max_pool_drain: RTL and testbench

Consumer end of the max-pool window stream. It samples pixel data read from the feature-map buffer, tagged by the one-hot window-element select from the max-pool address generator, and reduces each 2x2 window to its signed maximum. Each result is written to the output buffer at out_base + window index, in row-major window order. It asserts done after the last of (matrix_size-1)^2 windows has been written.

---
 rtl/max_pool_pkg.sv | 19 +
 rtl/max_pool_cmp.sv | 13 +
 rtl/max_pool_drain.sv | 122 ++++++++++++
 tb/tb_max_pool_drain.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_pkg.sv
// Shared definitions for the max-pool address generator and drain: element
// select encodings, window count helper and the COLLECT/DONE state encoding.
package max_pool_pkg;

  localparam logic [3:0] SEL_E0 = 4'b0001;  // (x,   y)
  localparam logic [3:0] SEL_E1 = 4'b0010;  // (x,   y+1)
  localparam logic [3:0] SEL_E2 = 4'b0100;  // (x+1, y)
  localparam logic [3:0] SEL_E3 = 4'b1000;  // (x+1, y+1)

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } pool_state_t;

  function automatic int out_windows(input int matrix_size);
    return (matrix_size - 1) * (matrix_size - 1);
  endfunction

endpackage

// File: rtl/max_pool_cmp.sv
// Combinational signed two-input maximum; ties return a.
// Zero latency, no flow control.
module max_pool_cmp #(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  output logic [data_width-1:0] max_out
);

  assign max_out = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/max_pool_drain.sv
// Reduces each sel-tagged 2x2 window to its signed max and writes it at out_base+window.
// One cycle from element 3 to wr_en; no backpressure (enable=0 stalls and holds state).
module max_pool_drain
  import max_pool_pkg::*;
#(
  parameter int matrix_size = 3,
  parameter int add_size    = 14,
  parameter int data_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [data_width-1:0] data_in,
  input  logic [3:0]            sel,
  input  logic [add_size-1:0]   out_base,
  output logic                  wr_en,
  output logic [add_size-1:0]   wr_add,
  output logic [data_width-1:0] wr_data,
  output logic                  done,
  output logic                  seq_err
);

  localparam int WINDOWS = out_windows(matrix_size);
  localparam int CW      = (WINDOWS > 1) ? $clog2(WINDOWS + 1) : 1;

  pool_state_t           state, state_n;
  logic [1:0]            exp, exp_n;
  logic [data_width-1:0] acc, acc_n;
  logic [CW-1:0]         win_cnt, win_cnt_n;
  logic                  wr_en_n, done_n, seq_err_n;
  logic [add_size-1:0]   wr_add_n;
  logic [data_width-1:0] wr_data_n;
  logic [data_width-1:0] max_val;
  logic                  beat_vld, multi_hot;
  logic [1:0]            k_idx;

  max_pool_cmp #(.data_width(data_width)) u_cmp (
    .a       (acc),
    .b       (data_in),
    .max_out (max_val)
  );

  assign beat_vld  = enable && (state == COLLECT) && (sel != 4'b0000);
  assign multi_hot = (sel & (sel - 4'd1)) != 4'b0000;

  always_comb begin
    k_idx = 2'd0;
    case (sel)
      SEL_E1:  k_idx = 2'd1;
      SEL_E2:  k_idx = 2'd2;
      SEL_E3:  k_idx = 2'd3;
      default: k_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_n   = state;
    exp_n     = exp;
    acc_n     = acc;
    win_cnt_n = win_cnt;
    wr_en_n   = 1'b0;
    wr_add_n  = wr_add;
    wr_data_n = wr_data;
    done_n    = done;
    seq_err_n = seq_err;

    if (beat_vld) begin
      if (multi_hot) begin
        seq_err_n = 1'b1;
      end else if (k_idx == 2'd0) begin
        // Element 0 always opens a fresh window, even mid-window.
        acc_n = data_in;
        exp_n = 2'd1;
        if (exp != 2'd0) seq_err_n = 1'b1;
      end else if (k_idx != exp) begin
        seq_err_n = 1'b1;
        exp_n     = 2'd0;
      end else if (k_idx == 2'd3) begin
        wr_en_n   = 1'b1;
        wr_data_n = max_val;
        wr_add_n  = out_base + add_size'(win_cnt);
        win_cnt_n = win_cnt + 1'b1;
        exp_n     = 2'd0;
        if (win_cnt == CW'(WINDOWS - 1)) begin
          done_n  = 1'b1;
          state_n = DONE;
        end
      end else begin
        acc_n = max_val;
        exp_n = exp + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp     <= 2'd0;
      acc     <= '0;
      win_cnt <= '0;
      wr_en   <= 1'b0;
      wr_add  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      exp     <= exp_n;
      acc     <= acc_n;
      win_cnt <= win_cnt_n;
      wr_en   <= wr_en_n;
      wr_add  <= wr_add_n;
      wr_data <= wr_data_n;
      done    <= done_n;
      seq_err <= seq_err_n;
    end
  end

endmodule

// File: tb/tb_max_pool_drain.sv
// Scoreboard bench for max_pool_drain: directed windows push expected writes,
// a negedge monitor pops and checks address, data and write cycle.
module tb_max_pool_drain;
  import max_pool_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  sel = '0;
  logic [13:0] out_base = 14'd100;
  logic        wr_en;
  logic [13:0] wr_add;
  logic [15:0] wr_data;
  logic        done;
  logic        seq_err;

  typedef struct {
    logic [13:0] add;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  max_pool_drain #(.matrix_size(3), .add_size(14), .data_width(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .data_in  (data_in),
    .sel      (sel),
    .out_base (out_base),
    .wr_en    (wr_en),
    .wr_add   (wr_add),
    .wr_data  (wr_data),
    .done     (done),
    .seq_err  (seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_wr: add=%0d data=%0h cyc=%0d", wr_add, wr_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_add", 32'(wr_add), 32'(e.add));
        chk("wr_data", 32'(wr_data), 32'(e.dat));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic en, input logic [3:0] s, input int d);
    @(posedge clk);
    #1;
    enable  = en;
    sel     = s;
    data_in = 16'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 4'b0000, 0);
  endtask

  // Gap cycles alternate a disabled (but otherwise provocative) beat with an empty sel.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) drive(1'b0, SEL_E3, 32767);
      else            drive(1'b1, 4'b0000, 0);
    end
  endtask

  task automatic feed_win(input int d0, input int d1, input int d2, input int d3,
                          input int g, input int ea, input int ed, input bit expw);
    drive(1'b1, SEL_E0, d0); gap(g);
    drive(1'b1, SEL_E1, d1); gap(g);
    drive(1'b1, SEL_E2, d2); gap(g);
    drive(1'b1, SEL_E3, d3);
    if (expw) sb.push_back('{14'(ea), 16'(ed), cyc + 1});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; enable = 1'b1; sel = 4'b0000; data_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      idle(1);
      t++;
    end
    idle(3);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_add", 32'(wr_add), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_seq_err", 32'(seq_err), 0);

    // 1: four back-to-back windows, done with the last write
    feed_win(1, 5, -3, 2, 0, 100, 5, 1'b1);
    feed_win(-8, -2, -7, -4, 0, 101, -2, 1'b1);
    feed_win(0, 0, 0, 0, 0, 102, 0, 1'b1);
    feed_win(7, 9, 9, -1, 0, 103, 9, 1'b1);
    @(negedge clk);
    chk("t1_done_before", 32'(done), 0);
    idle(1);
    @(negedge clk);
    chk("t1_done_with_wr", 32'(done), 1);
    drain("t1_drain");
    chk("t1_seq_err", 32'(seq_err), 0);

    // 2: reset mid-window discards partial window and window count
    do_reset();
    drive(1'b1, SEL_E0, 10);
    drive(1'b1, SEL_E1, 20);
    do_reset();
    feed_win(3, 4, 1, 2, 0, 100, 4, 1'b1);
    drain("t2_drain");
    chk("t2_seq_err", 32'(seq_err), 0);
    chk("t2_done", 32'(done), 0);

    // 3: out-of-order element flags seq_err, then a clean window writes
    do_reset();
    drive(1'b1, SEL_E0, 6);
    drive(1'b1, SEL_E2, 7);
    idle(2);
    @(negedge clk);
    chk("t3_seq_err", 32'(seq_err), 1);
    feed_win(1, 2, 3, 4, 0, 100, 4, 1'b1);
    drain("t3_drain");
    chk("t3_seq_err_sticky", 32'(seq_err), 1);

    // 4: gaps between elements hold acc/exp
    do_reset();
    feed_win(-1, -5, -9, -2, 3, 100, -1, 1'b1);
    drain("t4_drain");
    chk("t4_seq_err", 32'(seq_err), 0);

    // 5: beats ignored after done; reset re-arms
    do_reset();
    feed_win(1, 2, 3, 4, 0, 100, 4, 1'b1);
    feed_win(-1, -1, -1, -1, 0, 101, -1, 1'b1);
    feed_win(10, -10, 3, 3, 0, 102, 10, 1'b1);
    feed_win(-20, -30, -25, -21, 0, 103, -20, 1'b1);
    drain("t5a_drain");
    feed_win(50, 50, 50, 50, 0, 0, 0, 1'b0);
    drain("t5b_drain");
    chk("t5_done_held", 32'(done), 1);
    chk("t5_add_held", 32'(wr_add), 103);
    chk("t5_data_held", 32'(wr_data), 32'(16'hffec));
    do_reset();
    @(negedge clk);
    chk("t5_done_cleared", 32'(done), 0);
    feed_win(5, 6, 7, 8, 0, 100, 8, 1'b1);
    drain("t5c_drain");

    // 6: address wrap and multi-hot select
    do_reset();
    out_base = 14'd16382;
    drive(1'b1, SEL_E0, 5);
    drive(1'b1, SEL_E1, 6);
    drive(1'b1, 4'b0011, 1000);
    drive(1'b1, SEL_E2, -7);
    drive(1'b1, SEL_E3, -8);
    sb.push_back('{14'd16382, 16'd6, cyc + 1});
    feed_win(-100, -200, -300, -50, 0, 16383, -50, 1'b1);
    feed_win(2, 2, 2, 2, 0, 0, 2, 1'b1);
    feed_win(0, -1, 1, 0, 0, 1, 1, 1'b1);
    drain("t6_drain");
    chk("t6_seq_err", 32'(seq_err), 1);
    chk("t6_done", 32'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
